lcd8080_bus_arbiter: RTL

Sequences the 8-bit 8080-style LCD write bus (CS_n, RS, WR_n, RD_n, REST_n, DATA[7:0]) and shares it between two requesters. The requesters are a CPU command/parameter port (single bytes) and a pixel stream port (RGB565 words sent as two bytes). It runs the panel hardware-reset sequence after reset and on request. It sits between the Nios II system's LCD port logic and the top-level LCD pins.

---
 rtl/lcd8080_bus_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd8080_bus_arbiter.sv
// 8080-style LCD write-bus sequencer: runs the panel hardware-reset sequence and
// shares the bus round-robin between a CPU byte port and an RGB565 pixel port.
module lcd8080_bus_arbiter #(
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int RST_LOW_CYC  = 500000,
  parameter int RST_WAIT_CYC = 6000000,
  parameter int CNT_W        = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_start,
  input  logic        cpu_valid,
  input  logic        cpu_rs,
  input  logic [7:0]  cpu_data,
  output logic        cpu_ready,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        init_done,
  output logic        busy,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic        lcd_rest_n,
  output logic [7:0]  lcd_data
);

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_WR_LO,
    ST_WR_HI
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOW_LD  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_LD = CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LOW_LD   = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WR_HIGH_LD  = CNT_W'(WR_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic             GRANT_CPU   = 1'b0;
  localparam logic             GRANT_PIX   = 1'b1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       next_byte_q, next_byte_d;
  logic             more_q, more_d;
  logic             last_grant_q, last_grant_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             pix_ready_q, pix_ready_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             cs_n_q, wr_n_q, rest_n_q, init_done_q, busy_q;

  logic handshake;
  logic cnt_zero;
  logic on_bus_d;
  logic in_init_d;

  // A registered ready marks the IDLE cycle in which the request is taken.
  assign handshake = cpu_ready_q | pix_ready_q;
  assign cnt_zero  = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    next_byte_d  = next_byte_q;
    more_d       = more_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    rs_d         = rs_q;
    cpu_ready_d  = 1'b0;
    pix_ready_d  = 1'b0;

    case (state_q)
      ST_RST_LOW: begin
        if (cnt_zero) begin
          state_d = ST_RST_WAIT;
          cnt_d   = RST_WAIT_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_IDLE: begin
        // A committed handshake wins over a same-cycle init_start.
        if (handshake) begin
          state_d = ST_SETUP;
          more_d  = pix_ready_q;
          if (pix_ready_q) begin
            data_d      = pix_data[15:8];
            next_byte_d = pix_data[7:0];
            rs_d        = 1'b1;
          end else begin
            data_d = cpu_data;
            rs_d   = cpu_rs;
          end
        end else if (init_start) begin
          state_d = ST_RST_LOW;
          cnt_d   = RST_LOW_LD;
        end
      end
      ST_SETUP: begin
        state_d = ST_WR_LO;
        cnt_d   = WR_LOW_LD;
      end
      ST_WR_LO: begin
        if (cnt_zero) begin
          state_d = ST_WR_HI;
          cnt_d   = WR_HIGH_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WR_HI: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (more_q) begin
          state_d = ST_SETUP;
          data_d  = next_byte_q;
          more_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_RST_LOW;
        cnt_d   = RST_LOW_LD;
      end
    endcase

    // Grant is decided one cycle ahead so ready comes straight from a flop.
    if (state_d == ST_IDLE) begin
      if (cpu_valid && (!pix_valid || (last_grant_q == GRANT_PIX))) begin
        cpu_ready_d  = 1'b1;
        last_grant_d = GRANT_CPU;
      end else if (pix_valid) begin
        pix_ready_d  = 1'b1;
        last_grant_d = GRANT_PIX;
      end
    end
  end

  assign on_bus_d  = (state_d == ST_SETUP) || (state_d == ST_WR_LO) || (state_d == ST_WR_HI);
  assign in_init_d = (state_d == ST_RST_LOW) || (state_d == ST_RST_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RST_LOW;
      cnt_q        <= RST_LOW_LD;
      next_byte_q  <= 8'h00;
      more_q       <= 1'b0;
      last_grant_q <= GRANT_PIX;
      cpu_ready_q  <= 1'b0;
      pix_ready_q  <= 1'b0;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      rest_n_q     <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      next_byte_q  <= next_byte_d;
      more_q       <= more_d;
      last_grant_q <= last_grant_d;
      cpu_ready_q  <= cpu_ready_d;
      pix_ready_q  <= pix_ready_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      cs_n_q       <= !on_bus_d;
      wr_n_q       <= (state_d != ST_WR_LO);
      rest_n_q     <= (state_d != ST_RST_LOW);
      init_done_q  <= !in_init_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign cpu_ready  = cpu_ready_q;
  assign pix_ready  = pix_ready_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign lcd_cs_n   = cs_n_q;
  assign lcd_rs     = rs_q;
  assign lcd_wr_n   = wr_n_q;
  assign lcd_rd_n   = 1'b1;
  assign lcd_rest_n = rest_n_q;
  assign lcd_data   = data_q;

endmodule
